// File: rtl/fade_pkg.sv
// Shared types for the LED fade controller: the fade sequencer state encoding.
`timescale 1ns/1ps
package fade_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HIGH = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LOW  = 3'd4
    } fade_state_t;

endpackage

// File: rtl/pwm_core.sv
// PWM engine: free-running period counter, duty compare and end-of-period tick.
// The counter is held at zero while i_clear is high so a fade cycle always
// starts on a clean period boundary.
`timescale 1ns/1ps
module pwm_core #(
    parameter int PWM_INTERVAL = 1200,
    parameter int DW           = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic [DW-1:0] i_duty,
    output logic          o_pwm,
    output logic          o_tick
);

    localparam logic [DW-1:0] L_LAST = DW'(PWM_INTERVAL - 1);
    localparam logic [DW-1:0] L_ONE  = DW'(1);

    logic [DW-1:0] r_count;

    // Period counter: 0..PWM_INTERVAL-1, wraps, cleared by reset or i_clear.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (r_count == L_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + L_ONE;
        end
    end

    // Duty 0 never drives high; duty PWM_INTERVAL always does, since count < PWM_INTERVAL.
    assign o_pwm  = (r_count < i_duty);
    assign o_tick = (r_count == L_LAST);

endmodule

// File: rtl/led_fade_ctrl.sv
// LED fade sequencer: ramps PWM duty up, holds at full, ramps down, holds at
// zero, then either repeats (loop) or returns to idle with a done pulse.
// Duty only changes on the last count of a period, so every period is whole.
`timescale 1ns/1ps
module led_fade_ctrl
    import fade_pkg::*;
#(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_PERIODS = 10,
    parameter int DUTY_STEP    = 12,
    parameter int HOLD_PERIODS = 100
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              loop,
    output logic                              pwm_out,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(PWM_INTERVAL+1)-1:0] duty
);

    localparam int DW   = $clog2(PWM_INTERVAL + 1);
    localparam int CMAX = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [DW:0]   L_STEP_X    = (DW+1)'(DUTY_STEP);
    localparam logic [DW:0]   L_FULL_X    = (DW+1)'(PWM_INTERVAL);
    localparam logic [DW-1:0] L_STEP      = DW'(DUTY_STEP);
    localparam logic [DW-1:0] L_FULL      = DW'(PWM_INTERVAL);
    localparam logic [CW-1:0] L_STEP_LAST = CW'(STEP_PERIODS - 1);
    localparam logic [CW-1:0] L_HOLD_LAST = CW'(HOLD_PERIODS - 1);
    localparam logic [CW-1:0] L_CNT_ONE   = CW'(1);

    if (PWM_INTERVAL < 2 || DUTY_STEP < 1 || DUTY_STEP > PWM_INTERVAL ||
        STEP_PERIODS < 1 || HOLD_PERIODS < 1) begin : g_param_check
        $error("led_fade_ctrl: illegal parameter combination");
    end

    fade_state_t   r_state, w_state_nxt;
    logic [DW-1:0] r_duty,  w_duty_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_done,  w_done_nxt;
    logic [DW:0]   w_sum;
    logic          w_tick;
    logic          w_pwm;
    logic          w_clear;

    assign w_clear = (r_state == IDLE);

    pwm_core #(
        .PWM_INTERVAL (PWM_INTERVAL),
        .DW           (DW)
    ) u_pwm_core (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_duty  (r_duty),
        .o_pwm   (w_pwm),
        .o_tick  (w_tick)
    );

    // State, duty, step/hold counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state, next-duty and counter logic; stop overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_sum       = {1'b0, r_duty} + L_STEP_X;

        if (stop) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_duty_nxt = '0;
                    w_cnt_nxt  = '0;
                    if (start) begin
                        w_state_nxt = RAMP_UP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RAMP_UP: begin
                    if (w_tick) begin
                        if (r_cnt == L_STEP_LAST) begin
                            w_cnt_nxt = '0;
                            if (w_sum >= L_FULL_X) begin
                                w_duty_nxt  = L_FULL;
                                w_state_nxt = HOLD_HIGH;
                            end else begin
                                w_duty_nxt = w_sum[DW-1:0];
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + L_CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                HOLD_HIGH: begin
                    if (w_tick) begin
                        if (r_cnt == L_HOLD_LAST) begin
                            w_cnt_nxt   = '0;
                            w_state_nxt = RAMP_DOWN;
                        end else begin
                            w_cnt_nxt = r_cnt + L_CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                RAMP_DOWN: begin
                    if (w_tick) begin
                        if (r_cnt == L_STEP_LAST) begin
                            w_cnt_nxt = '0;
                            if (r_duty <= L_STEP) begin
                                w_duty_nxt  = '0;
                                w_state_nxt = HOLD_LOW;
                            end else begin
                                w_duty_nxt = r_duty - L_STEP;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + L_CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                HOLD_LOW: begin
                    if (w_tick) begin
                        if (r_cnt == L_HOLD_LAST) begin
                            w_cnt_nxt = '0;
                            if (loop) begin
                                w_state_nxt = RAMP_UP;
                            end else begin
                                w_state_nxt = IDLE;
                                w_done_nxt  = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + L_CNT_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_duty_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign pwm_out = w_pwm;
    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign duty    = r_duty;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Scoreboard bench for led_fade_ctrl with PWM_INTERVAL=10, STEP_PERIODS=2,
// DUTY_STEP=4, HOLD_PERIODS=3. Expected per-cycle outputs are queued as
// stimulus is applied and compared on every falling clock edge.
`timescale 1ns/1ps
module tb_led_fade_ctrl;

    localparam int PI = 10;
    localparam int SP = 2;
    localparam int DS = 4;
    localparam int HP = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       loop;
    logic       pwm_out;
    logic       busy;
    logic       done;
    logic [3:0] duty;

    typedef struct packed {
        logic [3:0] duty;
        logic       pwm;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   exp_cnt   = 0;
    int   done_seen = 0;

    led_fade_ctrl #(
        .PWM_INTERVAL (PI),
        .STEP_PERIODS (SP),
        .DUTY_STEP    (DS),
        .HOLD_PERIODS (HP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .pwm_out (pwm_out),
        .busy    (busy),
        .done    (done),
        .duty    (duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop one expected entry per cycle and compare all outputs.
    always @(negedge clk) begin : sb_check
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if ({duty, pwm_out, busy, done} !== e) begin
                n_bad++;
                $display("FAIL scoreboard t=%0t: got duty=%0d pwm=%b busy=%b done=%b, want duty=%0d pwm=%b busy=%b done=%b",
                         $time, duty, pwm_out, busy, done, e.duty, e.pwm, e.busy, e.done);
            end
        end
    end

    // Count done pulses independently of the scoreboard.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Busy cycles at a given duty; pwm follows the expected period position.
    task automatic push_seg(input int d, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.duty = d[3:0];
            e.pwm  = (exp_cnt < d);
            e.busy = 1'b1;
            e.done = 1'b0;
            sb_q.push_back(e);
            exp_cnt = (exp_cnt + 1) % PI;
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) sb_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e      = '0;
        e.done = 1'b1;
        sb_q.push_back(e);
    endtask

    // One complete fade cycle: 20 cycles per step, 30 cycles per hold.
    task automatic push_cycle();
        push_seg(0, 20);
        push_seg(4, 20);
        push_seg(8, 20);
        push_seg(10, 50);
        push_seg(6, 20);
        push_seg(2, 20);
        push_seg(0, 30);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; loop = 1'b0;
        wait_cyc(2);
        n_cmp++; if (pwm_out !== 1'b0) begin n_bad++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (duty !== 4'd0)    begin n_bad++; $display("FAIL reset_duty: got %0d want 0", duty); end
        rst = 1'b0; start = 1'b0;
        push_idle(5);
        wait_cyc(5);
    endtask

    task automatic test_full_cycle();
        int d0;
        d0 = done_seen;
        exp_cnt = 0;
        push_cycle();
        push_done();
        push_idle(5);
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(185);
        n_cmp++;
        if (done_seen - d0 !== 1) begin
            n_bad++; $display("FAIL full_cycle_done_count: got %0d want 1", done_seen - d0);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_seen;
        exp_cnt = 0;
        push_seg(0, 20);
        push_seg(4, 20);
        push_seg(8, 5);
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(44);
        stop = 1'b1;
        push_idle(1);
        wait_cyc(1);
        stop = 1'b0;
        push_idle(100);
        wait_cyc(100);
        n_cmp++;
        if (done_seen !== d0) begin
            n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen - d0);
        end
    endtask

    task automatic test_loop();
        int d0;
        d0 = done_seen;
        loop = 1'b1;
        exp_cnt = 0;
        push_cycle();
        push_cycle();
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(49);
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(309);
        push_seg(0, 5);
        wait_cyc(5);
        stop = 1'b1;
        loop = 1'b0;
        push_idle(1);
        wait_cyc(1);
        stop = 1'b0;
        push_idle(10);
        wait_cyc(10);
        n_cmp++;
        if (done_seen !== d0) begin
            n_bad++; $display("FAIL loop_no_done: got %0d pulses want 0", done_seen - d0);
        end
    endtask

    task automatic test_start_stop_same();
        push_idle(20);
        start = 1'b1;
        stop  = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        wait_cyc(19);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL start_stop_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_rst_hold_high();
        int d0;
        d0 = done_seen;
        exp_cnt = 0;
        push_seg(0, 20);
        push_seg(4, 20);
        push_seg(8, 20);
        push_seg(10, 15);
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(74);
        rst = 1'b1;
        push_idle(1);
        wait_cyc(1);
        rst = 1'b0;
        push_idle(50);
        wait_cyc(50);
        n_cmp++;
        if (done_seen !== d0) begin
            n_bad++; $display("FAIL rst_hold_no_done: got %0d pulses want 0", done_seen - d0);
        end
        exp_cnt = 0;
        push_seg(0, 20);
        push_seg(4, 5);
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
        wait_cyc(24);
        stop = 1'b1;
        push_idle(3);
        wait_cyc(1);
        stop = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        test_reset();
        test_full_cycle();
        test_abort();
        test_loop();
        test_start_stop_same();
        test_rst_hold_high();
        n_cmp++;
        if (sb_q.size() !== 0) begin
            n_bad++; $display("FAIL sb_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_fade_ctrl.md
LED_FADE_CTRL -- requirements
Module: led_fade_ctrl

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200: clock cycles per PWM period (100 us at 12 MHz).
REQ-002 SHALL have parameter STEP_PERIODS, default 10: PWM periods between duty updates.
REQ-003 SHALL have parameter DUTY_STEP, default 12: duty change per update, in clock counts.
REQ-004 SHALL have parameter HOLD_PERIODS, default 100: PWM periods spent at full and at zero brightness.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  single-cycle request to begin a fade cycle.
REQ-008 SHALL have port stop  input  1  single-cycle abort request.
REQ-009 SHALL have port loop  input  1  when high, repeat fade cycles continuously.
REQ-010 SHALL have port pwm_out  output  1  LED drive.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a non-looping fade cycle completes.
REQ-013 SHALL have port duty  output  $clog2(PWM_INTERVAL+1)  current duty, in clock counts.

Function
REQ-014 SHALL run a period counter over 0..PWM_INTERVAL-1 that wraps to 0; period_tick is high when the count equals PWM_INTERVAL-1.
REQ-015 SHALL drive pwm_out = (period count < duty): duty 0 gives constant low; duty PWM_INTERVAL gives constant high.
REQ-016 SHALL write the duty register only on a period_tick cycle, so a new duty takes effect from count 0 of the next period (no partial periods).
REQ-017 SHALL implement FSM states IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN, HOLD_LOW.
REQ-018 In IDLE: start (with stop low) SHALL move to RAMP_UP and clear the period counter and step counter; duty stays 0.
REQ-019 In RAMP_UP: on every STEP_PERIODS-th period_tick, duty SHALL become min(duty+DUTY_STEP, PWM_INTERVAL), computed at duty width+1 bits; on reaching PWM_INTERVAL, go to HOLD_HIGH in the same cycle.
REQ-020 In HOLD_HIGH: after HOLD_PERIODS period_ticks, go to RAMP_DOWN; duty unchanged.
REQ-021 In RAMP_DOWN: on every STEP_PERIODS-th period_tick, duty SHALL become max(duty-DUTY_STEP, 0) with no underflow; on reaching 0, go to HOLD_LOW.
REQ-022 In HOLD_LOW: after HOLD_PERIODS period_ticks, go to RAMP_UP if loop=1 (loop sampled only on this tick); otherwise go to IDLE and assert done for exactly one cycle, coincident with busy falling.
REQ-023 The step/hold counter SHALL clear on every state transition.
REQ-024 stop in any non-IDLE state SHALL force IDLE on the next clock, with duty=0, pwm_out=0, busy=0 and no done pulse.
REQ-025 start while busy SHALL be ignored.
REQ-026 start and stop in the same cycle SHALL resolve to stop: remain or go to IDLE.
REQ-027 Parameter legality SHALL be 1<=DUTY_STEP<=PWM_INTERVAL, STEP_PERIODS>=1, HOLD_PERIODS>=1, PWM_INTERVAL>=2; illegal values are an elaboration error.

Reset
REQ-028 rst SHALL take priority over all inputs; on the next clock: state IDLE, all counters 0, duty 0, pwm_out 0, busy 0, done 0.
REQ-029 rst asserted mid-operation SHALL abandon the cycle with no done pulse; operation resumes only on a new start.

Structure
REQ-030 Package fade_pkg SHALL hold the fade_state_t enum; parameter defaults stay local to the module.
REQ-031 Sub-module pwm_core SHALL contain the period counter, the compare and period_tick generation, with a clear input; led_fade_ctrl contains the FSM and duty register.

Verification (PWM_INTERVAL=10, STEP_PERIODS=2, DUTY_STEP=4, HOLD_PERIODS=3)
REQ-032 Reset: rst high 2 cycles -> pwm_out=0, busy=0, done=0, duty=0.
REQ-033 Full cycle: start, loop=0 ->
- duty steps 0,4,8,10 every 20 cycles; HOLD_HIGH for 30 cycles with pwm_out constant high;
- duty steps 10,6,2,0; HOLD_LOW for 30 cycles;
- done pulses 1 cycle and busy falls in the same cycle.
REQ-034 PWM shape: with duty=4, each 10-cycle period -> pwm_out high at counts 0..3 and low at counts 4..9.
REQ-035 Abort: stop while duty=8 in RAMP_UP -> next cycle duty=0, pwm_out=0, busy=0; no done pulse at any time.
REQ-036 Loop: loop=1 -> HOLD_LOW exits to RAMP_UP with no done pulse; a start pulse while busy causes no state change.
REQ-037 Corner cases:
- start and stop in the same cycle while IDLE -> stays IDLE.
- rst during HOLD_HIGH -> reset values on the next cycle; the cycle is abandoned with no done pulse.
